// File: rtl/canvas_writer_pkg.sv
// Shared colour definitions for the drawing pipeline, plus a small helper
// used by the frame-buffer writer.
package canvas_writer_pkg;

  localparam int COLOR_WIDTH = 3;

  typedef enum logic [COLOR_WIDTH-1:0] {
    COLOR_NONE   = 3'd0,
    COLOR_BLACK  = 3'd1,
    COLOR_RED    = 3'd2,
    COLOR_GREEN  = 3'd3,
    COLOR_BLUE   = 3'd4,
    COLOR_YELLOW = 3'd5,
    COLOR_CYAN   = 3'd6,
    COLOR_WHITE  = 3'd7
  } color_e;

  function automatic logic is_drawable(input logic [COLOR_WIDTH-1:0] color);
    return color != COLOR_NONE;
  endfunction

endpackage

// File: rtl/canvas_writer_pixel_fifo.sv
// Small synchronous FIFO on a register array. Pop is ignored when empty and
// push is ignored when full unless a pop frees a slot on the same edge.
module pixel_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem_reg [DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [PW:0]   count_reg;
  logic          do_push;
  logic          do_pop;

  assign empty     = (count_reg == '0);
  assign full      = (count_reg == (PW+1)'(DEPTH));
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);
  assign head_data = mem_reg[rd_ptr_reg];
  assign count     = count_reg;

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (do_push && wr_ptr_reg == PW'(gi)) mem_reg[gi] <= push_data;
      end
    end
  endgenerate

endmodule

// File: rtl/canvas_writer.sv
// Filters the tool pixel stream, queues surviving pixels and turns them into
// frame-buffer writes whenever the write port is granted.
module canvas_writer
  import canvas_writer_pkg::*;
#(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int DEPTH  = 8,
  localparam int XW = $clog2(WIDTH),
  localparam int YW = $clog2(HEIGHT),
  localparam int AW = $clog2(WIDTH * HEIGHT)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [XW-1:0]          pixel_x,
  input  logic [YW-1:0]          pixel_y,
  input  logic [COLOR_WIDTH-1:0] pixel_color,
  input  logic                   mem_grant,
  input  logic                   clear_overflow,
  output logic                   mem_we,
  output logic [AW-1:0]          mem_addr,
  output logic [COLOR_WIDTH-1:0] mem_data,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overflow,
  output logic [7:0]             drop_count
);
  localparam int EW = XW + YW + COLOR_WIDTH;

  logic                   last_valid_reg;
  logic [XW-1:0]          last_x_reg;
  logic [YW-1:0]          last_y_reg;
  logic [COLOR_WIDTH-1:0] last_color_reg;
  logic                   mem_we_reg;
  logic [AW-1:0]          mem_addr_reg;
  logic [COLOR_WIDTH-1:0] mem_data_reg;
  logic                   overflow_reg;
  logic [7:0]             drop_count_reg;

  logic                   in_range;
  logic                   is_dup;
  logic                   want_push;
  logic                   do_push;
  logic                   do_pop;
  logic                   drop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [EW-1:0]          head_data;
  logic [XW-1:0]          head_x;
  logic [YW-1:0]          head_y;
  logic [COLOR_WIDTH-1:0] head_color;
  logic [AW-1:0]          addr_next;

  // Wrapped tool coordinates come out as all-ones and fail the range test.
  always_comb begin
    in_range  = ({1'b0, pixel_x} < (XW+1)'(WIDTH)) && ({1'b0, pixel_y} < (YW+1)'(HEIGHT));
    is_dup    = last_valid_reg && (pixel_x == last_x_reg) && (pixel_y == last_y_reg)
                && (pixel_color == last_color_reg);
    want_push = in_valid && is_drawable(pixel_color) && in_range && !is_dup;
    do_pop    = mem_grant && !fifo_empty;
    do_push   = want_push && (!fifo_full || do_pop);
    drop      = want_push && fifo_full && !do_pop;
  end

  pixel_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (do_push),
    .push_data ({pixel_x, pixel_y, pixel_color}),
    .pop       (do_pop),
    .head_data (head_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign {head_x, head_y, head_color} = head_data;
  assign addr_next = AW'(head_y) * AW'(WIDTH) + AW'(head_x);

  always_ff @(posedge clk) begin
    if (reset) begin
      last_valid_reg <= 1'b0;
      last_x_reg     <= '0;
      last_y_reg     <= '0;
      last_color_reg <= COLOR_NONE;
      mem_we_reg     <= 1'b0;
      mem_addr_reg   <= '0;
      mem_data_reg   <= COLOR_NONE;
      overflow_reg   <= 1'b0;
      drop_count_reg <= '0;
    end else begin
      // A pixel lost to a full FIFO leaves this untouched so a repeat is retried.
      if (do_push) begin
        last_valid_reg <= 1'b1;
        last_x_reg     <= pixel_x;
        last_y_reg     <= pixel_y;
        last_color_reg <= pixel_color;
      end
      mem_we_reg <= do_pop;
      if (do_pop) begin
        mem_addr_reg <= addr_next;
        mem_data_reg <= head_color;
      end
      if (drop) begin
        overflow_reg <= 1'b1;
        if (clear_overflow)              drop_count_reg <= 8'd1;
        else if (drop_count_reg != 8'hFF) drop_count_reg <= drop_count_reg + 8'd1;
      end else if (clear_overflow) begin
        overflow_reg   <= 1'b0;
        drop_count_reg <= '0;
      end
    end
  end

  assign mem_we     = mem_we_reg;
  assign mem_addr   = mem_addr_reg;
  assign mem_data   = mem_data_reg;
  assign overflow   = overflow_reg;
  assign drop_count = drop_count_reg;

endmodule
